axi_burst_master: RTL
=====================

# axi_burst_master

AXI4 initiator that turns simple core-side read/write burst requests into AXI INCR transactions, and streams the data beats between the core and the bus. It sits between a soft-CPU core, or a DMA-style client, and the interconnect or an AXI RAM slave. Each port of a slave such as the shared AXI RAM is driven by one instance. One transaction is outstanding at a time; read and write are never in flight together.

## Interface
Parameters:
- ID_W_WIDTH, 4, width of AWID/BID
- ID_R_WIDTH, 4, width of ARID/RID
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data bus width; power of two, ≥8
- MASTER_ID, 0, constant driven on AWID/ARID

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock domain; reset is synchronous and active-high
- req_valid  in  1  core request valid
- req_ready  out  1  request accepted when both high
- req_write  in  1  1 = write burst, 0 = read burst
- req_addr  in  ADDR_WIDTH  byte start address; low $clog2(DATA_WIDTH/8) bits ignored (forced 0)
- req_len  in  8  beats − 1 (0..255)
- wr_valid / wr_ready  in / out  1  write-data stream handshake
- wr_data  in  DATA_WIDTH  write beat
- rd_valid / rd_ready  out / in  1  read-data stream handshake
- rd_data  out  DATA_WIDTH  read beat
- rd_last  out  1  final read beat of the burst
- done  out  1  one-cycle pulse at transaction end
- err  out  1  transaction error flag, valid with done
- axi_m  axi_if.m  full AXI4 master modport. ARSIZE/AWSIZE = $clog2(DATA_WIDTH/8); ARBURST/AWBURST = 2'b01; WSTRB = all ones.

## Operation
- FSM states: IDLE, AR, R, AW, W, B.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch addr, len and write; clear beat_cnt and err_acc.
  - Go to AW if req_write, else AR.
- AR:
  - ARVALID = 1; ARADDR/ARLEN/ARID are held stable from the latched values.
  - On ARREADY go to R.
- R:
  - rd_valid = RVALID, rd_data = RDATA, RREADY = rd_ready. All are combinational pass-through.
  - rd_last = (beat_cnt == len).
  - On each RVALID && RREADY:
    - beat_cnt increments.
    - err_acc |= RRESP[1].
    - err_acc |= (RLAST != (beat_cnt == len)).
  - The burst terminates on beat number len, whatever RLAST says; then go to IDLE.
- AW:
  - AWVALID = 1 with latched fields.
  - On AWREADY go to W. W never starts before the AW handshake.
- W:
  - WVALID = wr_valid, WDATA = wr_data, wr_ready = WREADY.
  - WLAST = (beat_cnt == len).
  - On each handshake beat_cnt increments; after the beat with WLAST go to B.
- B:
  - BREADY = 1.
  - On BVALID, err_acc |= BRESP[1]; go to IDLE.
- done pulses for 1 cycle on the cycle after the final R beat or the B handshake. err = err_acc, which holds until the next accepted request.
- beat_cnt is 8 bits and never exceeds len. The address is not incremented locally; the slave owns the burst address sequencing.
- RID and BID are ignored; only one transaction is ever outstanding.

## Timing
- While rst is high:
  - State is IDLE.
  - beat_cnt, len, addr and err are 0.
  - done is 0.
  - All AXI VALID/READY outputs and req_ready are forced 0.
- First cycle after rst falls: req_ready = 1.
- Request accepted in cycle T → ARVALID/AWVALID asserted in T+1. An address handshake in cycle A makes R/W active from A+1.
- Minimum single-beat read: accept at T, AR handshake at T+1, R beat at T+2, done at T+3. req_ready is high again at T+3.
- Minimum single-beat write: accept at T, AW at T+1, W at T+2, B at T+3, done at T+4.
- VALID, once raised, stays high with stable payload until the handshake (AXI rule). This applies to ARVALID and AWVALID. WVALID follows wr_valid; the core keeps its valid high until accepted.
- Backpressure on either side stalls the handshake with no beat loss or duplication.
- rst asserted mid-burst: abandon immediately, drop all VALIDs the next edge, no done pulse. The slave must also be reset.
- req_valid arriving outside IDLE is ignored; req_ready = 0 there.

## Test plan
- Read, len = 0, addr = 0x10, slave returns 0xDEADBEEF with RLAST=1, RRESP=0 → one rd beat 0xDEADBEEF with rd_last=1; done at T+3; err = 0; ARLEN = 0, ARSIZE = 2.
- Write, len = 3, data 1..4, slave AWREADY delayed 5 cycles → AWADDR held stable for 5 cycles; 4 W beats with WLAST only on beat 4; BREADY = 1; done once; err = 0.
- Read, len = 7, rd_ready toggled 1-0-1-0 → exactly 8 beats delivered in order, none duplicated; RREADY mirrors rd_ready.
- Write with BRESP = 2'b10 (SLVERR) → err = 1 with done. The next clean read clears err to 0.
- Read, len = 3, slave raises RLAST on beat 2 → 4 beats consumed, err = 1.
- rst pulsed during W beat 2 of len = 5 → all VALIDs 0 and req_ready 0 while rst is high. After release, req_ready = 1, no done, and a new read completes normally.

Source files
------------

// File: rtl/axi_burst_master_if.sv
// AXI4 bus bundle between one burst master and its slave.
// The m modport is the initiator view; s is the responder view.
interface axi_if #(
  parameter int ID_W_WIDTH = 4,
  parameter int ID_R_WIDTH = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // write address channel
  logic [ID_W_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awlock;
  logic [3:0]              awcache;
  logic [2:0]              awprot;
  logic [3:0]              awqos;
  logic                    awvalid;
  logic                    awready;
  // write data channel
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  // write response channel
  logic [ID_W_WIDTH-1:0]   bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  // read address channel
  logic [ID_R_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arlock;
  logic [3:0]              arcache;
  logic [2:0]              arprot;
  logic [3:0]              arqos;
  logic                    arvalid;
  logic                    arready;
  // read data channel
  logic [ID_R_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport m (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport s (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_burst_master.sv
// AXI4 burst initiator: turns core read/write burst requests into single
// outstanding INCR transactions and streams the data beats straight
// through between the core and the bus.
module axi_burst_master #(
  parameter int ID_W_WIDTH = 4,
  parameter int ID_R_WIDTH = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MASTER_ID  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [7:0]            req_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  done,
  output logic                  err,
  axi_if.m                      axi_m
);

  localparam int unsigned SIZE_LOG2 = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {ADDR_WIDTH{1'b1}} << SIZE_LOG2;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AR   = 3'd1;
  localparam logic [2:0] S_R    = 3'd2;
  localparam logic [2:0] S_AW   = 3'd3;
  localparam logic [2:0] S_W    = 3'd4;
  localparam logic [2:0] S_B    = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            beat_cnt_q, beat_cnt_d;
  logic                  err_acc_q, err_acc_d;
  logic                  done_q, done_d;

  logic                  run;
  logic                  beat_last;
  logic                  r_hs;
  logic                  w_hs;

  // IDs and the low response bit carry no information with one transaction in flight
  logic                  unused_resp;
  assign unused_resp = ^{axi_m.rid, axi_m.bid, axi_m.rresp[0], axi_m.bresp[0]};

  assign run       = !rst;
  assign beat_last = (beat_cnt_q == len_q);
  assign r_hs      = (state_q == S_R) && axi_m.rvalid && rd_ready;
  assign w_hs      = (state_q == S_W) && wr_valid && axi_m.wready;

  // Next-state, request latch, beat counting and error accumulation
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    err_acc_d  = err_acc_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d     = req_addr & ADDR_MASK;
          len_d      = req_len;
          beat_cnt_d = '0;
          err_acc_d  = 1'b0;
          state_d    = req_write ? S_AW : S_AR;
        end
      end
      S_AR: begin
        if (axi_m.arready) state_d = S_R;
      end
      S_R: begin
        if (r_hs) begin
          err_acc_d = err_acc_q | axi_m.rresp[1] | (axi_m.rlast != beat_last);
          // the local beat count ends the burst; a misplaced RLAST only flags an error
          if (beat_last) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
          end
        end
      end
      S_AW: begin
        if (axi_m.awready) state_d = S_W;
      end
      S_W: begin
        if (w_hs) begin
          if (beat_last) state_d = S_B;
          else beat_cnt_d = beat_cnt_q + 8'd1;
        end
      end
      S_B: begin
        if (axi_m.bvalid) begin
          err_acc_d = err_acc_q | axi_m.bresp[1];
          state_d   = S_IDLE;
          done_d    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      err_acc_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      err_acc_q  <= err_acc_d;
      done_q     <= done_d;
    end
  end

  // Core-side handshakes and status; gated by rst so nothing leaks before the first edge
  assign req_ready = run && (state_q == S_IDLE);
  assign wr_ready  = run && (state_q == S_W) && axi_m.wready;
  assign rd_valid  = run && (state_q == S_R) && axi_m.rvalid;
  assign rd_data   = axi_m.rdata;
  assign rd_last   = (state_q == S_R) && beat_last;
  assign done      = run && done_q;
  assign err       = run && err_acc_q;

  // Write address channel driven from the latched request
  assign axi_m.awid    = ID_W_WIDTH'(MASTER_ID);
  assign axi_m.awaddr  = addr_q;
  assign axi_m.awlen   = len_q;
  assign axi_m.awsize  = 3'(SIZE_LOG2);
  assign axi_m.awburst = 2'b01;
  assign axi_m.awlock  = 1'b0;
  assign axi_m.awcache = '0;
  assign axi_m.awprot  = '0;
  assign axi_m.awqos   = '0;
  assign axi_m.awvalid = run && (state_q == S_AW);

  // Write data channel is a pass-through of the core stream
  assign axi_m.wdata  = wr_data;
  assign axi_m.wstrb  = '1;
  assign axi_m.wlast  = beat_last;
  assign axi_m.wvalid = run && (state_q == S_W) && wr_valid;

  // Write response channel
  assign axi_m.bready = run && (state_q == S_B);

  // Read address channel driven from the latched request
  assign axi_m.arid    = ID_R_WIDTH'(MASTER_ID);
  assign axi_m.araddr  = addr_q;
  assign axi_m.arlen   = len_q;
  assign axi_m.arsize  = 3'(SIZE_LOG2);
  assign axi_m.arburst = 2'b01;
  assign axi_m.arlock  = 1'b0;
  assign axi_m.arcache = '0;
  assign axi_m.arprot  = '0;
  assign axi_m.arqos   = '0;
  assign axi_m.arvalid = run && (state_q == S_AR);

  // Read data channel ready mirrors the core consumer
  assign axi_m.rready = run && (state_q == S_R) && rd_ready;

endmodule
